// File: rtl/rpm_div_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rpm_div_scheduler
// Purpose  : Shares one iterative 32-bit restoring divider between NUM_CH
//            encoder channels. Each accepted sample (m0 pulse count, m1
//            reference-tick count, direction) becomes a signed, saturated RPM
//            value: rpm = +/- min(m0 * RPM_K / m1, 2^(DATA_WIDTH-1)-1).
//            Requests are granted round-robin through valid/ready handshakes.
//            A conversion takes 34 cycles from handshake to result strobe.
// Ports    : clk, rstn           - clock, async active-low reset
//            req_valid_i/ready_o - per-channel request handshake
//            req_m0_i/m1_i/dir_i - per-channel packed operands
//            busy_o              - conversion in progress
//            rpm_valid_o/ch_o/data_o/div0_err_o - result strobe and payload
//            rpm_ch_data_o       - last result per channel, packed
// Revision : 1.0 - initial release
// ============================================================================
module rpm_div_scheduler #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int RPM_K      = 367647
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH-1:0]            req_valid_i,
  output logic [NUM_CH-1:0]            req_ready_o,
  input  logic [4*NUM_CH-1:0]          req_m0_i,
  input  logic [16*NUM_CH-1:0]         req_m1_i,
  input  logic [NUM_CH-1:0]            req_dir_i,
  output logic                         busy_o,
  output logic                         rpm_valid_o,
  output logic [2:0]                   rpm_ch_o,
  output logic [DATA_WIDTH-1:0]        rpm_data_o,
  output logic [DATA_WIDTH*NUM_CH-1:0] rpm_ch_data_o,
  output logic                         div0_err_o
);

  localparam int                    CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [1:0]            ST_IDLE = 2'd0;
  localparam logic [1:0]            ST_MUL  = 2'd1;
  localparam logic [1:0]            ST_DIV  = 2'd2;
  localparam logic [31:0]           K_32    = 32'(RPM_K);
  localparam logic [31:0]           SAT_32  = 32'((64'd1 << (DATA_WIDTH-1)) - 64'd1);
  localparam logic [DATA_WIDTH-1:0] SAT_W   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [CH_W-1:0]       LAST_CH = CH_W'(NUM_CH-1);

  logic [1:0]            state, state_nxt;
  logic [CH_W-1:0]       last_grant, grant_idx, cap_ch;
  logic                  grant_found, handshake, last_iter;
  logic [3:0]            sel_m0, cap_m0;
  logic [15:0]           sel_m1, cap_m1;
  logic                  sel_dir, cap_dir;
  logic [31:0]           quo, quo_nxt;
  logic [15:0]           rem, rem_nxt, rem_diff;
  logic [16:0]           rem_shift;
  logic                  rem_ge;
  logic [4:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] mag, result;

  // --------------------------------------------------------------------------
  // Round-robin search starting one past the last granted channel.
  // --------------------------------------------------------------------------
  always_comb begin : grant_search
    logic [CH_W-1:0] idx_ch;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_ch      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_ch = CH_W'((int'(last_grant) + 1 + i) % NUM_CH);
      if (!grant_found && req_valid_i[idx_ch]) begin
        grant_found = 1'b1;
        grant_idx   = idx_ch;
      end
    end
  end

  // Operand mux for the granted channel.
  always_comb begin
    sel_m0  = '0;
    sel_m1  = '0;
    sel_dir = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_idx == CH_W'(c)) begin
        sel_m0  = req_m0_i[4*c +: 4];
        sel_m1  = req_m1_i[16*c +: 16];
        sel_dir = req_dir_i[c];
      end
    end
  end

  assign handshake = (state == ST_IDLE) && grant_found;
  assign last_iter = (state == ST_DIV) && (bit_cnt == 5'd31);

  // --------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (handshake) state_nxt = ST_MUL;
      ST_MUL:  state_nxt = ST_DIV;
      ST_DIV:  if (last_iter) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state != ST_IDLE);
    req_ready_o = '0;
    if (handshake) req_ready_o[grant_idx] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // One restoring-division step. The remainder is always below the 16-bit
  // divisor, so 16 bits hold it and the low 16 bits of the subtraction are
  // exact whenever the subtraction is taken.
  // --------------------------------------------------------------------------
  assign rem_shift = {rem, quo[31]};
  assign rem_ge    = (rem_shift >= {1'b0, cap_m1});
  assign rem_diff  = rem_shift[15:0] - cap_m1;
  assign rem_nxt   = rem_ge ? rem_diff : rem_shift[15:0];
  assign quo_nxt   = {quo[30:0], rem_ge};

  // Result formed from the final quotient bit. A zero divisor bypasses the
  // quotient; m0 = 0 needs no special case since the quotient is then 0 and
  // negating 0 stays 0. Saturating to +max before negation keeps the range
  // symmetric.
  always_comb begin
    if (cap_m1 == 16'd0)      mag = SAT_W;
    else if (quo_nxt > SAT_32) mag = SAT_W;
    else                       mag = quo_nxt[DATA_WIDTH-1:0];
    result = cap_dir ? -mag : mag;
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant  <= LAST_CH;
      cap_ch      <= '0;
      cap_m0      <= '0;
      cap_m1      <= '0;
      cap_dir     <= 1'b0;
      quo         <= '0;
      rem         <= '0;
      bit_cnt     <= '0;
      rpm_valid_o <= 1'b0;
      div0_err_o  <= 1'b0;
      rpm_ch_o    <= '0;
      rpm_data_o  <= '0;
    end else begin
      rpm_valid_o <= 1'b0;
      div0_err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            cap_ch     <= grant_idx;
            cap_m0     <= sel_m0;
            cap_m1     <= sel_m1;
            cap_dir    <= sel_dir;
            last_grant <= grant_idx;
          end
        end
        ST_MUL: begin
          // 15 * RPM_K fits comfortably in 32 bits.
          quo     <= {28'd0, cap_m0} * K_32;
          rem     <= '0;
          bit_cnt <= '0;
        end
        ST_DIV: begin
          quo     <= quo_nxt;
          rem     <= rem_nxt;
          bit_cnt <= bit_cnt + 5'd1;
          if (last_iter) begin
            rpm_valid_o <= 1'b1;
            div0_err_o  <= (cap_m1 == 16'd0);
            rpm_ch_o    <= 3'(cap_ch);
            rpm_data_o  <= result;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-channel hold registers, refreshed on the same edge as the strobe.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] slot;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                 slot <= '0;
      else if (last_iter && cap_ch == CH_W'(c)) slot <= result;
    end
    assign rpm_ch_data_o[c*DATA_WIDTH +: DATA_WIDTH] = slot;
  end

endmodule
`default_nettype wire

// File: tb/tb_rpm_div_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rpm_div_scheduler
// Purpose  : Self-checking bench for rpm_div_scheduler. A transaction-level
//            model (round-robin grant, result = arithmetic formula, strobe
//            34 cycles after handshake) is compared against the DUT on every
//            negative clock edge; directed sequences pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rpm_div_scheduler;
  localparam int NCH = 2;
  localparam int W   = 16;
  localparam int K   = 367647;
  localparam int LAT = 34;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NCH-1:0]       valid, ready, dir;
  logic [4*NCH-1:0]     m0;
  logic [16*NCH-1:0]    m1;
  logic                 busy, rpm_valid, div0_err;
  logic [2:0]           rpm_ch;
  logic [W-1:0]         rpm_data;
  logic [W*NCH-1:0]     ch_data;

  rpm_div_scheduler #(.NUM_CH(NCH), .DATA_WIDTH(W), .RPM_K(K)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(valid), .req_ready_o(ready),
    .req_m0_i(m0), .req_m1_i(m1), .req_dir_i(dir),
    .busy_o(busy), .rpm_valid_o(rpm_valid), .rpm_ch_o(rpm_ch),
    .rpm_data_o(rpm_data), .rpm_ch_data_o(ch_data), .div0_err_o(div0_err)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result straight from the arithmetic definition.
  function automatic logic [W-1:0] ref_rpm(input int a, input int b, input bit d);
    longint q;
    longint smax;
    smax = (longint'(1) << (W-1)) - 1;
    if (b == 0) q = smax;
    else        q = (longint'(a) * K) / b;
    if (q > smax) q = smax;
    if (d) q = -q;
    return W'(q);
  endfunction

  // ---------------- model state ----------------
  bit           pend = 0;
  int           due, p_ch, last_m = NCH-1;
  logic [W-1:0] p_data;
  bit           p_err;
  int           hold_ch = 0;
  logic [W-1:0] hold_data = '0;
  logic [W-1:0] model_ch [NCH];
  logic [NCH-1:0] hs_seen = '0;

  // DUT event logs for directed checks
  int           hs_cyc[$], hs_ch[$], st_cyc[$], st_ch[$];
  logic [W-1:0] st_data[$];
  bit           st_err[$];

  task automatic clear_logs();
    hs_cyc.delete(); hs_ch.delete(); st_cyc.delete();
    st_ch.delete(); st_data.delete(); st_err.delete();
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin : monitor
    logic [NCH-1:0]   exp_ready;
    logic [W*NCH-1:0] exp_pack;
    bit               exp_v;
    int               g;
    if (!rstn) begin
      pend      = 0;
      last_m    = NCH-1;
      hold_ch   = 0;
      hold_data = '0;
      for (int c = 0; c < NCH; c++) model_ch[c] = '0;
    end
    exp_v = rstn && pend && (cyc == due);
    if (exp_v) begin
      hold_ch          = p_ch;
      hold_data        = p_data;
      model_ch[p_ch]   = p_data;
      pend             = 0;
    end
    check("rpm_valid", {63'd0, rpm_valid}, {63'd0, exp_v});
    check("div0_err", {63'd0, div0_err}, {63'd0, exp_v && p_err});
    check("rpm_ch", {61'd0, rpm_ch}, 64'(hold_ch));
    check("rpm_data", {48'd0, rpm_data}, {48'd0, hold_data});
    for (int c = 0; c < NCH; c++) exp_pack[W*c +: W] = model_ch[c];
    check("rpm_ch_data", 64'(ch_data), 64'(exp_pack));
    check("busy", {63'd0, busy}, {63'd0, pend});

    exp_ready = '0;
    g = -1;
    if (rstn && !pend) begin
      for (int i = 0; i < NCH; i++) begin
        if (g < 0 && valid[(last_m + 1 + i) % NCH]) g = (last_m + 1 + i) % NCH;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    check("req_ready", 64'(ready), 64'(exp_ready));
    if (g >= 0) begin
      pend   = 1;
      due    = cyc + LAT;
      p_ch   = g;
      p_data = ref_rpm(int'(m0[4*g +: 4]), int'(m1[16*g +: 16]), dir[g]);
      p_err  = (m1[16*g +: 16] == 16'd0);
      last_m = g;
    end

    // Logs of what the DUT actually did, for the literal checks.
    hs_seen = valid & ready;
    if (rstn) begin
      for (int c = 0; c < NCH; c++) begin
        if (hs_seen[c]) begin hs_cyc.push_back(cyc); hs_ch.push_back(c); end
      end
      if (rpm_valid) begin
        st_cyc.push_back(cyc); st_ch.push_back(int'(rpm_ch));
        st_data.push_back(rpm_data); st_err.push_back(div0_err);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit keep = 0;

  task automatic step();
    @(posedge clk); #1;
    if (!keep) valid = valid & ~hs_seen;
  endtask

  task automatic set_req(input int c, input int a, input int b, input bit d);
    m0[4*c +: 4]   = 4'(a);
    m1[16*c +: 16] = 16'(b);
    dir[c]         = d;
    valid[c]       = 1'b1;
  endtask

  task automatic wait_strobes(input int n, input int budget, input string nm);
    int k = 0;
    while (st_cyc.size() < n && k < budget) begin step(); k++; end
    check({nm, "_strobes"}, 64'(st_cyc.size() >= n), 64'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((pend || valid != '0) && k < 200) begin step(); k++; end
    check("idle_reached", 64'(pend || valid != '0), 64'd0);
  endtask

  task automatic single(input int a, input int b, input bit d,
                        input logic [W-1:0] exp, input bit e, input string nm);
    clear_logs();
    step();
    set_req(0, a, b, d);
    wait_strobes(1, 120, nm);
    check({nm, "_data"}, 64'(st_data[0]), 64'(exp));
    check({nm, "_err"}, 64'(st_err[0]), 64'(e));
    check({nm, "_ch"}, 64'(st_ch[0]), 64'd0);
    check({nm, "_lat"}, 64'(st_cyc[0] - hs_cyc[0]), 64'(LAT));
    wait_idle();
  endtask

  function automatic int rand_m1();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 0;
    if (r < 5)  return $urandom_range(1, 60);
    return $urandom_range(1, 65535);
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    int rel, k;
    valid = '0; m0 = '0; m1 = '0; dir = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data", 64'(rpm_data), 64'd0);
    check("reset_ready", 64'(ready), 64'd0);

    // Both channels valid straight out of reset.
    @(posedge clk); #1;
    clear_logs();
    rstn = 1'b1;
    rel  = cyc;
    set_req(0, 4, 8193, 1'b0);
    set_req(1, 4, 8193, 1'b1);
    wait_strobes(2, 150, "rr");
    check("rr_hs0_cyc", 64'(hs_cyc[0] - rel), 64'd0);
    check("rr_hs0_ch", 64'(hs_ch[0]), 64'd0);
    check("rr_hs1_cyc", 64'(hs_cyc[1] - rel), 64'd34);
    check("rr_hs1_ch", 64'(hs_ch[1]), 64'd1);
    check("rr_st0_cyc", 64'(st_cyc[0] - rel), 64'd34);
    check("rr_st1_cyc", 64'(st_cyc[1] - rel), 64'd68);
    check("rr_st0_data", 64'(st_data[0]), 64'h00B3);
    check("rr_st1_data", 64'(st_data[1]), 64'hFF4D);
    check("rr_st1_ch", 64'(st_ch[1]), 64'd1);
    check("rr_ch_data", 64'(ch_data), 64'hFF4D_00B3);
    wait_idle();

    single(4, 100, 1'b0, 16'h3971, 1'b0, "m1_100");
    single(15, 1, 1'b0, 16'h7FFF, 1'b0, "sat_pos");
    single(15, 1, 1'b1, 16'h8001, 1'b0, "sat_neg");
    single(5, 0, 1'b0, 16'h7FFF, 1'b1, "div0");
    single(0, 77, 1'b1, 16'h0000, 1'b0, "m0_zero");

    // Continuous requests on both channels: grants must alternate.
    clear_logs();
    keep = 1;
    step();
    set_req(0, 7, 300, 1'b0);
    set_req(1, 9, 1234, 1'b1);
    wait_strobes(4, 200, "fair");
    keep  = 0;
    valid = '0;
    for (int i = 1; i < 4; i++) begin
      check("fair_alt", 64'(hs_ch[i] != hs_ch[i-1]), 64'd1);
      check("fair_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(LAT));
    end
    wait_idle();

    // Reset in the middle of a division.
    clear_logs();
    step();
    set_req(1, 6, 500, 1'b0);
    k = 0;
    while (hs_cyc.size() == 0 && k < 50) begin step(); k++; end
    check("rst_started", 64'(hs_cyc.size()), 64'd1);
    while (cyc < hs_cyc[0] + 12 && k < 100) begin step(); k++; end
    rstn = 1'b0;
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ch_data", 64'(ch_data), 64'd0);
    step();
    rstn = 1'b1;
    repeat (40) step();
    check("rst_no_strobe", 64'(st_cyc.size()), 64'd0);
    set_req(0, 3, 2000, 1'b0);
    set_req(1, 3, 2000, 1'b1);
    @(negedge clk);
    check("rst_grant", 64'(ready), 64'b01);
    wait_strobes(2, 150, "rst_after");
    wait_idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      for (int c = 0; c < NCH; c++) begin
        if (!valid[c] && $urandom_range(0, 3) == 0)
          set_req(c, $urandom_range(0, 15), rand_m1(), 1'($urandom_range(0, 1)));
        else if (valid[c] && $urandom_range(0, 40) == 0)
          valid[c] = 1'b0;
      end
    end
    valid = '0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #(100 * 20000);
    n_fail++;
    $display("FAIL watchdog: simulation exceeded 20000 cycles");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/rpm_div_scheduler.md
Name: rpm_div_scheduler

Overview:
- Shares one iterative 32-bit divider between NUM_CH encoder measurement channels, converting each (m0 pulse count, m1 reference-tick count, direction) sample into a signed RPM value.
- Sits between the per-motor encoder counter front-ends and the PID loops.
- Removes the per-channel combinational divider.
- Round-robin arbitration with valid/ready request handshakes; one result pulse per accepted request.

Parameters:
- NUM_CH, 2, number of requesting encoder channels (2..8).
- DATA_WIDTH, 16, signed RPM output width.
- RPM_K, 367647, scale constant: 10 MHz * 60 / (408*4), integer.

Ports:
- clk  input  1  system clock (10 MHz).
- rstn  input  1  reset; asynchronous, active-low.
- req_valid_i  input  NUM_CH  per-channel request valid.
- req_ready_o  output  NUM_CH  per-channel accept; at most one bit high.
- req_m0_i  input  4*NUM_CH  per-channel pulse count; channel c at bits [4c+3:4c].
- req_m1_i  input  16*NUM_CH  per-channel reference-tick count; channel c at bits [16c+15:16c].
- req_dir_i  input  NUM_CH  per-channel direction: 0 forward, 1 reverse.
- busy_o  output  1  high while not IDLE.
- rpm_valid_o  output  1  one-cycle result strobe.
- rpm_ch_o  output  3  channel index of the current result.
- rpm_data_o  output  DATA_WIDTH  signed RPM of the current result.
- rpm_ch_data_o  output  DATA_WIDTH*NUM_CH  last result per channel, held until that channel's next result.
- div0_err_o  output  1  one-cycle strobe, coincident with rpm_valid_o, when m1 was 0.

Behaviour:
- Reset values: all outputs 0; state IDLE; last-grant pointer = NUM_CH-1, so channel 0 has first priority.
- States: IDLE, MUL, DIV.
- IDLE
  - Grant = first channel with valid, searching round-robin from (last_grant+1) mod NUM_CH.
  - req_ready_o is combinational: high only on the granted bit, and only while in IDLE.
  - On handshake (valid & ready): capture m0, m1, dir and the channel index; update last_grant; go to MUL.
  - No valid: stay in IDLE, ready all 0.
- MUL (1 cycle)
  - Numerator = m0 * RPM_K, 32-bit unsigned; max 15*367647 = 5,514,705, no overflow.
  - Load the divider: quotient register = numerator, remainder = 0, bit counter = 0.
  - Go to DIV.
- DIV (exactly 32 cycles)
  - Restoring division, one quotient bit per cycle, MSB first.
  - After iteration 31, register the result and return to IDLE.
- Result formation, registered at the edge ending the last DIV cycle:
  - If the 32-bit quotient > 2^(DATA_WIDTH-1)-1, saturate to 2^(DATA_WIDTH-1)-1.
  - If dir=1, output the two's-complement negation, so the range is symmetric and -2^(W-1) is never produced.
  - m1=0: skip the quotient, output +/- saturated magnitude, assert div0_err_o.
  - m0=0: result 0 regardless of dir.
- Latency and throughput:
  - Handshake in cycle T -> rpm_valid_o high in cycle T+34 for exactly 1 cycle.
  - rpm_ch_o and rpm_data_o change only at that edge and hold until the next result.
  - The matching rpm_ch_data_o slice updates at the same edge.
- Back-to-back: state is IDLE during the strobe cycle, so a new handshake may occur in cycle T+34. Sustained throughput is one result per 34 cycles.
- Requesters hold valid and operands stable until ready. Deasserting valid before ready is legal: the request is dropped with no result.
- Requests arriving while busy wait; ready stays 0 outside IDLE.
- Reset mid-operation aborts the conversion: no strobe; outputs, per-channel registers and the pointer return to reset values.
- Fairness: with all channels continuously valid, grants rotate 0,1,..,NUM_CH-1,0,...

Test Plan:
- Ch0 m0=4, m1=8193, dir=0 -> 34 cycles after handshake: rpm_valid_o=1, rpm_ch_o=0, rpm_data_o=179 (0x00B3), rpm_ch_data_o[15:0]=0x00B3.
- Ch1 m0=4, m1=8193, dir=1 -> rpm_data_o=0xFF4D (-179), rpm_ch_o=1, ch0 slice unchanged.
- Ch0 m0=4, m1=100 -> 14705 (0x3971).
- Ch0 m0=15, m1=1 with dir=0 then dir=1 -> saturate to 0x7FFF, then 0x8001.
- Ch0 m1=0 -> 0x7FFF with div0_err_o=1 in the same cycle as rpm_valid_o; m0=0, dir=1 -> 0x0000.
- Both channels valid from reset -> ch0 accepted at cycle 0, ch1 accepted at cycle 34, strobes at cycles 34 and 68.
- Continuous requests on both channels -> grants alternate.
- rstn low at cycle 10 of DIV -> no strobe; all outputs 0; next simultaneous request grants ch0.
